// File: rtl/bus_responder.sv
// bus_responder: word-addressed 8-bit memory slave driven by level strobes.
// A fresh 0->1 edge on exactly one of rd/wr (while idle) starts an access.
// The access waits WAIT_CYC cycles, then completes with a one-cycle ready
// pulse. Reads keep data_out/data_oe driven until both strobes drop.
// Accesses at or above MEM_DEPTH complete with err alongside ready. Reads
// return 8'hFF and writes are dropped. Simultaneous rd/wr edges give an
// err pulse and no access.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   rd, wr   in   level strobes, held for the whole access
//   addr     in   13-bit word address, sampled at request detection
//   data_in  in   write data, sampled on the edge leaving WR_COMMIT
//   data_out out  read data
//   data_oe  out  read data valid / bus drive enable
//   ready    out  one-cycle access-complete pulse
//   err      out  one-cycle illegal-access pulse
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a fresh strobe edge
// WAIT      | counting wait states; aborts if the active strobe drops
// RD_DRV    | read completes: ready, data_oe, data_out valid
// WR_COMMIT | write completes: ready, memory written on the leaving edge
// HOLD      | access done; wait for rd=0 and wr=0
module bus_responder #(
    parameter int MEM_DEPTH = 256,
    parameter int WAIT_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        wr,
    input  logic [12:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        ready,
    output logic        err
);

    localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [13:0] DEPTH     = 14'(MEM_DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYC);

    typedef enum logic [2:0] {IDLE, WAIT, RD_DRV, WR_COMMIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rd_prev_q, wr_prev_q;
    logic [AW-1:0]   idx_q, idx_d;
    logic            oor_q, oor_d;
    logic            acc_wr_q, acc_wr_d;
    logic            acc_rd_q, acc_rd_d;
    logic            coll_q, coll_d;
    logic [7:0]      data_out_q, data_out_d;

    logic [7:0]      mem [MEM_DEPTH];

    logic            rd_rise, wr_rise, addr_oor;
    logic [AW-1:0]   rd_idx;
    logic            rd_oor;
    logic [7:0]      rd_word;

    assign rd_rise  = rd & ~rd_prev_q;
    assign wr_rise  = wr & ~wr_prev_q;
    assign addr_oor = ({1'b0, addr} >= DEPTH);

    // With no wait states the read word is fetched on the detection edge
    // itself, before the address has been latched.
    always_comb begin
        rd_idx  = idx_q;
        rd_oor  = oor_q;
        if (state_q == IDLE) begin
            rd_idx = addr[AW-1:0];
            rd_oor = addr_oor;
        end
        rd_word = rd_oor ? 8'hFF : mem[rd_idx];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        oor_d      = oor_q;
        acc_wr_d   = acc_wr_q;
        acc_rd_d   = acc_rd_q;
        coll_d     = 1'b0;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (rd_rise && wr_rise) begin
                    coll_d   = 1'b1;
                    acc_rd_d = 1'b0;
                    acc_wr_d = 1'b0;
                    state_d  = HOLD;
                end else if (rd_rise || wr_rise) begin
                    idx_d    = addr[AW-1:0];
                    oor_d    = addr_oor;
                    acc_wr_d = wr_rise;
                    acc_rd_d = rd_rise;
                    if (WAIT_CYC == 0) begin
                        if (wr_rise) begin
                            state_d = WR_COMMIT;
                        end else begin
                            state_d    = RD_DRV;
                            data_out_d = rd_word;
                        end
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (acc_wr_q ? !wr : !rd) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d = 4'd0;
                    if (acc_wr_q) begin
                        state_d = WR_COMMIT;
                    end else begin
                        state_d    = RD_DRV;
                        data_out_d = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_DRV, WR_COMMIT: state_d = HOLD;
            HOLD: begin
                if (!rd && !wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rd_prev_q  <= 1'b1;
            wr_prev_q  <= 1'b1;
            idx_q      <= '0;
            oor_q      <= 1'b0;
            acc_wr_q   <= 1'b0;
            acc_rd_q   <= 1'b0;
            coll_q     <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_prev_q  <= rd;
            wr_prev_q  <= wr;
            idx_q      <= idx_d;
            oor_q      <= oor_d;
            acc_wr_q   <= acc_wr_d;
            acc_rd_q   <= acc_rd_d;
            coll_q     <= coll_d;
            data_out_q <= data_out_d;
        end
    end

    // Memory is never cleared; reset only blocks a commit on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && state_q == WR_COMMIT && !oor_q) begin
            mem[idx_q] <= data_in;
        end
    end

    assign ready    = (state_q == RD_DRV) || (state_q == WR_COMMIT);
    assign err      = (ready && oor_q) || coll_q;
    assign data_oe  = (state_q == RD_DRV) || (state_q == HOLD && acc_rd_q);
    assign data_out = data_out_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed testbench for bus_responder: one instance with WAIT_CYC=2 and
// one with WAIT_CYC=0, sharing clock and reset.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr;
    logic [12:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe, ready, err;

    logic        rd0, wr0;
    logic [12:0] addr0;
    logic [7:0]  data_in0;
    logic [7:0]  data_out0;
    logic        data_oe0, ready0, err0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bus_responder #(.MEM_DEPTH(256), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .ready(ready), .err(err)
    );

    bus_responder #(.MEM_DEPTH(256), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .rd(rd0), .wr(wr0), .addr(addr0),
        .data_in(data_in0), .data_out(data_out0), .data_oe(data_oe0),
        .ready(ready0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Outputs packed as {ready, err, data_oe, data_out}
    function automatic logic [31:0] outs();
        return {21'd0, ready, err, data_oe, data_out};
    endfunction

    function automatic logic [31:0] outs0();
        return {21'd0, ready0, err0, data_oe0, data_out0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rd = 0; wr = 0; addr = '0; data_in = '0;
        rd0 = 0; wr0 = 0; addr0 = '0; data_in0 = '0;
        tick(3);
        check("reset_outs",  outs(),  32'h000);
        check("reset_outs0", outs0(), 32'h000);
        rst = 1'b0;
        tick();

        // zero wait states: write then read, ready on the cycle after detection
        wr0 = 1; addr0 = 13'h010; data_in0 = 8'hA5;
        tick();
        check("w0_wr_ready", {31'd0, ready0}, 32'd1);
        wr0 = 0; tick(2);
        rd0 = 1; addr0 = 13'h010;
        tick();
        check("w0_rd_drv", outs0(), {21'd0, 3'b101, 8'hA5});
        rd0 = 0; tick(2);
        check("w0_idle_oe", {31'd0, data_oe0}, 32'd0);

        // write 0x5A to 0x010 with two wait states
        wr = 1; addr = 13'h010; data_in = 8'h5A;
        tick();
        check("wr_wait1_ready", {31'd0, ready}, 32'd0);
        tick();
        check("wr_wait2_ready", {31'd0, ready}, 32'd0);
        tick();
        check("wr_commit", outs(), {21'd0, 3'b100, 8'h00});
        tick();
        check("wr_hold_ready", {31'd0, ready}, 32'd0);
        wr = 0; tick();

        // read back, data_oe held through HOLD, addr changes ignored
        rd = 1; addr = 13'h010;
        tick(2);
        check("rd_wait_oe", {31'd0, data_oe}, 32'd0);
        addr = 13'h000;
        tick();
        check("rd_drv", outs(), {21'd0, 3'b101, 8'h5A});
        tick();
        check("rd_hold1", outs(), {21'd0, 3'b001, 8'h5A});
        tick();
        check("rd_hold2", outs(), {21'd0, 3'b001, 8'h5A});
        rd = 0; tick();
        check("rd_idle_oe", {31'd0, data_oe}, 32'd0);

        // out-of-range read
        rd = 1; addr = 13'h1F00;
        tick(3);
        check("oor_rd", outs(), {21'd0, 3'b111, 8'hFF});
        rd = 0; tick(2);

        // baseline at 0x000, then out-of-range write must not alias onto it
        wr = 1; addr = 13'h000; data_in = 8'h33;
        tick(3); wr = 0; tick(2);
        wr = 1; addr = 13'h1F00; data_in = 8'hC3;
        tick(3);
        check("oor_wr", {30'd0, ready, err}, 32'd3);
        wr = 0; tick(2);
        rd = 1; addr = 13'h000;
        tick(3);
        check("oor_wr_alias", {24'd0, data_out}, 32'h33);
        rd = 0; tick(2);

        // rd and wr rise together
        rd = 1; wr = 1; addr = 13'h000; data_in = 8'h99;
        tick();
        check("coll_err", outs() & 32'hF00, 32'h200);
        tick();
        check("coll_err_gone", {30'd0, ready, err}, 32'd0);
        rd = 0; tick();
        rd = 1; tick(3);
        check("coll_hold_no_rd", {30'd0, ready, data_oe}, 32'd0);
        rd = 0; wr = 0; tick();
        rd = 1; addr = 13'h000;
        tick(3);
        check("coll_mem", outs(), {21'd0, 3'b101, 8'h33});
        rd = 0; tick(2);

        // wr aborted in second WAIT cycle
        wr = 1; addr = 13'h020; data_in = 8'h11;
        tick(3); wr = 0; tick(2);
        wr = 1; addr = 13'h020; data_in = 8'hEE;
        tick(2);
        wr = 0; tick();
        check("abort_outs", {30'd0, ready, err}, 32'd0);
        tick();
        check("abort_outs2", {30'd0, ready, err}, 32'd0);
        rd = 1; addr = 13'h020;
        tick(3);
        check("abort_mem", {24'd0, data_out}, 32'h11);
        rd = 0; tick(2);

        // reset during WR_COMMIT suppresses the write
        wr = 1; addr = 13'h020; data_in = 8'h77;
        tick(3);
        check("rst_commit_ready", {31'd0, ready}, 32'd1);
        rst = 1; tick();
        check("rst_commit_outs", outs(), 32'h000);
        rst = 0; wr = 0; tick();
        rd = 1; addr = 13'h020;
        tick(3);
        check("rst_commit_mem", outs(), {21'd0, 3'b101, 8'h11});
        rd = 0; tick(2);

        // rd held through reset release starts nothing until re-raised
        rd = 1; rst = 1; addr = 13'h010;
        tick();
        rst = 0;
        tick(4);
        check("rd_held_rst", {30'd0, ready, data_oe}, 32'd0);
        rd = 0; tick();
        rd = 1;
        tick(3);
        check("rd_after_rst", outs(), {21'd0, 3'b101, 8'h5A});
        rd = 0; tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
